// File: rtl/data_ram.sv
// data_ram: word-organised data memory for an RV32I load/store stage.
// Combinational read with byte/halfword alignment and extension, byte-lane
// writes, alignment fault detection, and load/store activity counters.
module data_ram #(
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic [2:0]  mem_size_i,
   input  logic        mem_we_i,
   input  logic        mem_re_i,
   output logic [31:0] ram_data_o,
   output logic        fault_o,
   output logic [31:0] fault_addr_o,
   output logic [31:0] load_cnt_o,
   output logic [31:0] store_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   // Storage array; deliberately never reset so contents survive rst_n.
   logic [31:0] mem_q [DEPTH_WORDS];

   logic [AW-1:0] word_idx;
   logic          unused_addr_bits;

   // High address bits are dropped so accesses wrap modulo the array size.
   assign word_idx         = mem_addr_i[AW+1:2];
   assign unused_addr_bits = ^mem_addr_i[31:AW+2];

   logic is_byte;
   logic is_half;
   logic is_word;
   logic is_unsigned;
   logic size_bad;
   logic misalign;
   logic access_fault;

   // Decode funct3 into access width/extension and flag illegal encodings.
   always_comb begin
      is_byte     = 1'b0;
      is_half     = 1'b0;
      is_word     = 1'b0;
      is_unsigned = 1'b0;
      size_bad    = 1'b0;
      case (mem_size_i)
         3'b000:  is_byte = 1'b1;
         3'b001:  is_half = 1'b1;
         3'b010:  is_word = 1'b1;
         3'b100:  begin is_byte = 1'b1; is_unsigned = 1'b1; end
         3'b101:  begin is_half = 1'b1; is_unsigned = 1'b1; end
         default: size_bad = 1'b1;
      endcase
      misalign     = (is_half & mem_addr_i[0]) |
                     (is_word & (mem_addr_i[1:0] != 2'b00));
      // Faults only matter when something is actually being accessed.
      access_fault = (mem_we_i | mem_re_i) & (size_bad | misalign);
   end

   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Combinational read: select, align and extend the addressed data.
   always_comb begin
      rd_word = mem_q[word_idx];
      case (mem_addr_i[1:0])
         2'b00:   rd_byte = rd_word[7:0];
         2'b01:   rd_byte = rd_word[15:8];
         2'b10:   rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half    = mem_addr_i[1] ? rd_word[31:16] : rd_word[15:0];
      ram_data_o = 32'h0;
      if (mem_re_i && !access_fault) begin
         if (is_byte)
            ram_data_o = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         else if (is_half)
            ram_data_o = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         else
            ram_data_o = rd_word;
      end
   end

   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        store_en;

   // Build byte-lane enables and lane-replicated store data.
   always_comb begin
      wr_be   = 4'b0000;
      wr_data = mem_data_i;
      if (is_byte) begin
         wr_be   = 4'b0001 << mem_addr_i[1:0];
         wr_data = {4{mem_data_i[7:0]}};
      end else if (is_half) begin
         wr_be   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
         wr_data = {2{mem_data_i[15:0]}};
      end else if (is_word) begin
         wr_be   = 4'b1111;
      end
      store_en = rst_n & mem_we_i & ~access_fault;
   end

   // Array write; the old word is what the read path saw this cycle.
   always_ff @(posedge clk) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   logic        fault_q,      fault_d;
   logic [31:0] fault_addr_q, fault_addr_d;
   logic [31:0] load_cnt_q,   load_cnt_d;
   logic [31:0] store_cnt_q,  store_cnt_d;

   // Next-state for the fault pulse, captured address and counters.
   always_comb begin
      fault_d      = access_fault;
      fault_addr_d = access_fault ? mem_addr_i : fault_addr_q;
      load_cnt_d   = load_cnt_q;
      store_cnt_d  = store_cnt_q;
      if (mem_re_i && !access_fault) load_cnt_d  = load_cnt_q + 32'd1;
      if (mem_we_i && !access_fault) store_cnt_d = store_cnt_q + 32'd1;
   end

   // Status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_q      <= 1'b0;
         fault_addr_q <= 32'h0;
         load_cnt_q   <= 32'h0;
         store_cnt_q  <= 32'h0;
      end else begin
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         load_cnt_q   <= load_cnt_d;
         store_cnt_q  <= store_cnt_d;
      end
   end

   assign fault_o      = fault_q;
   assign fault_addr_o = fault_addr_q;
   assign load_cnt_o   = load_cnt_q;
   assign store_cnt_o  = store_cnt_q;

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, number of 32-bit words; SHALL be a power of two, at least 2.
REQ-002 Port clk  in  1  rising-edge clock for all sequential logic.
REQ-003 Port rst_n  in  1  reset; one clock, reset synchronous and active-low.
REQ-004 Port mem_addr_i  in  32  byte address from the access stage.
REQ-005 Port mem_data_i  in  32  store data; bytes taken from the LSBs.
REQ-006 Port mem_size_i  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Port mem_we_i  in  1  store request.
REQ-008 Port mem_re_i  in  1  load request.
REQ-009 Port ram_data_o  out  32  load result, aligned and extended.
REQ-010 Port fault_o  out  1  registered one-cycle pulse on a faulting access.
REQ-011 Port fault_addr_o  out  32  address of the most recent faulting access.
REQ-012 Port load_cnt_o  out  32  count of accepted loads.
REQ-013 Port store_cnt_o  out  32  count of accepted stores.

Function
REQ-014 Word index SHALL be mem_addr_i[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-015 An access SHALL fault on any of these conditions: H/HU with addr[0]=1; W with addr[1:0]!=00; size 011, 110 or 111.
REQ-016 A fault SHALL only be evaluated when mem_we_i or mem_re_i is 1.
REQ-017 Read path SHALL be combinational, giving same-cycle ram_data_o for the pipeline.
  - B/BU select byte addr[1:0].
  - H/HU select halfword addr[1].
  - B and H sign-extend; BU and HU zero-extend.
REQ-018 ram_data_o SHALL be 0 when mem_re_i=0 or the access faults.
REQ-019 A store SHALL update the array on the rising edge when rst_n=1, mem_we_i=1 and the access does not fault.
  - B writes only byte lane addr[1:0] with mem_data_i[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with mem_data_i[15:0].
  - W writes all four lanes.
  - Unwritten lanes SHALL keep their value.
REQ-020 A faulting store SHALL leave the array unchanged.
REQ-021 With mem_we_i=mem_re_i=1 in one cycle, the store SHALL take effect and ram_data_o SHALL show pre-store contents (read-before-write); both counters SHALL increment.
REQ-022 fault_o SHALL be 1 in the cycle after a faulting access and 0 otherwise. fault_addr_o SHALL load mem_addr_i on that edge and hold it until the next fault.
REQ-023 load_cnt_o SHALL increment by 1 per edge with mem_re_i=1 and no fault; store_cnt_o likewise for mem_we_i.
REQ-024 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Faulting accesses SHALL not be counted.

Reset
REQ-026 On a rising edge with rst_n=0:
  - fault_o, fault_addr_o, load_cnt_o and store_cnt_o SHALL go to 0.
  - Any store presented in that cycle SHALL be suppressed.
REQ-027 Array contents SHALL NOT be cleared by reset and SHALL be preserved across reset.
REQ-028 During reset, ram_data_o SHALL still follow REQ-017/018 combinationally.

Verification
REQ-029 Store word: SW 0x12345678 @0x10, then LW @0x10 -> 0x12345678; store_cnt_o=1, load_cnt_o=1.
REQ-030 Byte and half: after REQ-029, SB 0xAB @0x11 then:
  - LW @0x10 -> 0x1234AB78.
  - LB @0x11 -> 0xFFFFFFAB.
  - LBU @0x11 -> 0x000000AB.
  - LH @0x12 -> 0x00001234.
  - LHU @0x10 -> 0x0000AB78.
REQ-031 Misaligned:
  - SW 0xFFFFFFFF @0x12 -> array unchanged (LW @0x10 still 0x1234AB78).
  - Next cycle fault_o=1 and fault_addr_o=0x12; store_cnt_o unchanged.
  - LH @0x13 -> ram_data_o=0 and a fault pulse.
REQ-032 Simultaneous: mem_we_i=mem_re_i=1, SW 0xCAFEF00D @0x20 with word old=0 -> ram_data_o=0 that cycle; next-cycle LW @0x20 -> 0xCAFEF00D.
REQ-033 Wrap and reset:
  - With DEPTH_WORDS=4096, SW 0x55 @0x4000 -> LW @0x0 returns 0x55.
  - Assert rst_n=0 for one edge together with SW 0x77 @0x0 -> counters 0, fault_o=0, LW @0x0 still 0x55.
REQ-034 Counter wrap: force store_cnt_o to 0xFFFFFFFF, one SW -> store_cnt_o=0.
